// File: rtl/lotr_pkg.sv
// Shared definitions for the ring-side request queues: request record, default entry
// count and small bit-vector helpers used by the free-slot finder and output muxes.
package lotr_pkg;

  localparam int MRO_ENT_DEF = 4;
  localparam int RC_DATA_W   = 32;
  localparam int ENC_MAX     = 32;
  localparam int ENC_W       = $clog2(ENC_MAX);

  typedef struct packed {
    logic                 IsRdRsp;
    logic [RC_DATA_W-1:0] Data;
  } t_rc_req;

  // Index of the lowest clear bit; ENC_MAX-wide callers pad unused positions with ones.
  function automatic logic [ENC_W:0] findFirstZero(input logic [ENC_MAX-1:0] v);
    findFirstZero = (ENC_W+1)'(ENC_MAX);
    for (int i = ENC_MAX-1; i >= 0; i--)
      if (!v[i]) findFirstZero = (ENC_W+1)'(i);
  endfunction

  function automatic logic [ENC_W-1:0] ohToEnc(input logic [ENC_MAX-1:0] oh);
    ohToEnc = '0;
    for (int i = 0; i < ENC_MAX; i++)
      if (oh[i]) ohToEnc = ohToEnc | ENC_W'(i);
  endfunction

endpackage

// File: rtl/mro.sv
// Age matrix: older[r][c] = 1 means entry r was allocated before entry c. Reports the
// oldest masked entry per class; flops are cleared only through Dealloc (no reset pin).
module mro
  import lotr_pkg::*;
#(
  parameter int MRO_MSB = MRO_ENT_DEF-1,
  localparam int NUM_ENT = MRO_MSB+1
) (
  input  logic               Clk,
  input  logic               EnAlloc,
  input  logic [NUM_ENT-1:0] NextAlloc,
  input  logic [NUM_ENT-1:0] Dealloc,
  input  logic [NUM_ENT-1:0] Mask0,
  input  logic [NUM_ENT-1:0] Mask1,
  output logic [NUM_ENT-1:0] Oldest0,
  output logic [NUM_ENT-1:0] Oldest1
);

  logic [NUM_ENT-1:0][NUM_ENT-1:0] older;
  logic [NUM_ENT-1:0][NUM_ENT-1:0] col;
  logic [NUM_ENT-1:0]              cand0, cand1;

  // A new entry is younger than everything present, so its row clears and every
  // other row gains its column. NextAlloc never hits the row being written.
  for (genvar r = 0; r < NUM_ENT; r++) begin : gRow
    always_ff @(posedge Clk) begin
      if (Dealloc[r] | (EnAlloc & NextAlloc[r]))
        older[r] <= '0;
      else if (EnAlloc)
        older[r] <= older[r] | NextAlloc;
    end
  end

  always_comb begin
    col = '0;
    for (int i = 0; i < NUM_ENT; i++)
      for (int j = 0; j < NUM_ENT; j++)
        col[i][j] = older[j][i];
  end

  always_comb begin
    cand0 = '0;
    cand1 = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      cand0[i] = Mask0[i] & ~|(col[i] & Mask0);
      cand1[i] = Mask1[i] & ~|(col[i] & Mask1);
    end
    // With no candidate the matrix reports column 0; consumers must gate with the mask.
    Oldest0 = (|Mask0) ? cand0 : NUM_ENT'(1);
    Oldest1 = (|Mask1) ? cand1 : NUM_ENT'(1);
  end

endmodule

// File: rtl/mro_req_queue.sv
// Age-ordered request queue: stores requests in free entries, issues the oldest read
// response on port 0 and the oldest other command on port 1, FIFO within each class.
module mro_req_queue
  import lotr_pkg::*;
#(
  parameter int MRO_MSB = MRO_ENT_DEF-1,
  parameter int DATA_W  = 32,
  localparam int NUM_ENT = MRO_MSB+1,
  localparam int CNT_W   = $clog2(NUM_ENT+1)
) (
  input  logic              Clk,
  input  logic              RstN,
  input  logic              InValid,
  output logic              InReady,
  input  logic              InIsRdRsp,
  input  logic [DATA_W-1:0] InData,
  output logic              Out0Valid,
  input  logic              Out0Ready,
  output logic [DATA_W-1:0] Out0Data,
  output logic              Out1Valid,
  input  logic              Out1Ready,
  output logic [DATA_W-1:0] Out1Data,
  output logic [CNT_W-1:0]  Count,
  output logic              Full,
  output logic              Empty
);

  if (NUM_ENT > ENC_MAX) begin : gSizeChk
    $error("mro_req_queue: NUM_ENT exceeds helper width");
  end

  logic [NUM_ENT-1:0]             entValid, entIsRdRsp;
  logic [NUM_ENT-1:0][DATA_W-1:0] entData;
  logic [NUM_ENT-1:0]             allocOh, dealloc, mask0, mask1, oldest0, oldest1;
  logic [ENC_MAX-1:0]             validPad;
  logic [ENC_W:0]                 freeIdx;
  logic                           accept, issue0, issue1;

  // Free-slot finder: lowest-index invalid entry.
  always_comb begin
    validPad = '1;
    validPad[NUM_ENT-1:0] = entValid;
    freeIdx = findFirstZero(validPad);
    allocOh = '0;
    for (int i = 0; i < NUM_ENT; i++)
      allocOh[i] = (32'(freeIdx) == i);
  end

  assign Full    = (Count == CNT_W'(NUM_ENT));
  assign Empty   = (Count == '0);
  assign InReady = RstN & ~Full;
  assign accept  = InValid & InReady;

  assign mask0 = entValid & entIsRdRsp;
  assign mask1 = entValid & ~entIsRdRsp;

  assign Out0Valid = |(oldest0 & mask0);
  assign Out1Valid = |(oldest1 & mask1);
  assign issue0    = Out0Valid & Out0Ready;
  assign issue1    = Out1Valid & Out1Ready;

  // Holding dealloc high in reset clears the matrix on the first edge.
  assign dealloc = RstN ? ((issue0 ? oldest0 : '0) | (issue1 ? oldest1 : '0))
                        : '1;

  always_comb begin
    Out0Data = '0;
    Out1Data = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      Out0Data = Out0Data | ({DATA_W{oldest0[i]}} & entData[i]);
      Out1Data = Out1Data | ({DATA_W{oldest1[i]}} & entData[i]);
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      entValid   <= '0;
      entIsRdRsp <= '0;
      Count      <= '0;
    end else begin
      entValid   <= (entValid & ~dealloc) | (accept ? allocOh : '0);
      if (accept)
        entIsRdRsp <= (entIsRdRsp & ~allocOh) | (InIsRdRsp ? allocOh : '0);
      Count <= Count + CNT_W'(accept) - CNT_W'(issue0) - CNT_W'(issue1);
    end
  end

  for (genvar i = 0; i < NUM_ENT; i++) begin : gData
    always_ff @(posedge Clk)
      if (accept & allocOh[i]) entData[i] <= InData;
  end

  mro #(.MRO_MSB(MRO_MSB)) u_mro (
    .Clk       (Clk),
    .EnAlloc   (accept),
    .NextAlloc (allocOh),
    .Dealloc   (dealloc),
    .Mask0     (mask0),
    .Mask1     (mask1),
    .Oldest0   (oldest0),
    .Oldest1   (oldest1)
  );

  aNoAcceptFull: assert property (@(posedge Clk) disable iff (!RstN) !(accept && Full));
  aDeallocValid: assert property (@(posedge Clk) disable iff (!RstN) (dealloc & ~entValid) == '0);
  aCountPop:     assert property (@(posedge Clk) disable iff (!RstN)
                                  Count == CNT_W'($countones(entValid)));
  aOneHot:       assert property (@(posedge Clk) disable iff (!RstN)
                                  $onehot0(oldest0) && $onehot0(oldest1));

endmodule
